// File: rtl/riscv_32im_pkg.sv
// Shared types and constants for the RV32IM core slice.
//   fetch_entry_t : one prefetch-queue entry {pc, instr, err}
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), the payload of error entries
//   FETCH_Q_DEPTH : default prefetch depth and outstanding-request limit
package riscv_32im_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR     = 32'h00000013;
  localparam int          FETCH_Q_DEPTH = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used by the fetch stage, once for PC tags and once for
// the {pc, instr, err} prefetch queue.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empties the FIFO; push and pop are ignored that cycle
//   push_i/data_i : write one element (caller guarantees space)
//   pop_i         : drop the head (ignored when empty)
//   data_o        : head element, read from storage registers
//   count_o       : number of stored elements
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push = push_i & ~flush_i;
  assign w_pop  = pop_i & ~flush_i & (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= data_i;
  end

  assign data_o  = r_mem[r_rdPtr];
  assign count_o = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: forwards PCs from pc_gen to imem, tags each
// response with its PC, buffers {pc, instr, err} and hands entries to IF/ID.
// On flush, queued work is discarded and responses still in flight are
// counted in a drop counter so they are thrown away when they return.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned PCs bypass imem
// and become error entries carrying a NOP).
//   clk_i, rst_ni           : clock, async active-low reset
//   flush_i                 : redirect, kill all fetched and in-flight work
//   pc_valid_i/pc_ready_o   : PC handshake from pc_gen, pc_i address
//   imem_req_*              : request to imem, imem_addr_o address
//   imem_rsp_*              : in-order response, imem_instr_i data
//   id_*                    : head entry toward IF/ID
//   occupancy_o             : queued + in flight + pending drops
module fetch_unit
  import riscv_32im_pkg::*;
#(
  parameter int  DEPTH = FETCH_Q_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          pc_valid_i,
  output logic          pc_ready_o,
  input  logic [31:0]   pc_i,
  output logic          imem_req_valid_o,
  input  logic          imem_req_ready_i,
  output logic [31:0]   imem_addr_o,
  input  logic          imem_rsp_valid_i,
  output logic          imem_rsp_ready_o,
  input  logic [31:0]   imem_instr_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [31:0]   id_pc_o,
  output logic [31:0]   id_instr_o,
  output logic          id_err_o,
  output logic [CW-1:0] occupancy_o
);

  logic          r_active;
  logic [CW-1:0] r_dropCnt;
  logic [CW-1:0] w_qCount;
  logic [CW-1:0] w_liveInflight;
  logic [CW-1:0] w_total;
  logic          w_creditOk;
  logic          w_open;
  logic          w_misaligned;
  logic          w_misFire;
  logic          w_reqFire;
  logic          w_rspFire;
  logic          w_rspKeep;
  logic          w_rspStale;
  logic [31:0]   w_tagPc;
  logic          w_qPush;
  logic          w_qPop;
  logic          w_idValid;
  fetch_entry_t  w_qPushData;
  fetch_entry_t  w_head;

  // Credits never exceed DEPTH, so the CW-bit sum cannot wrap.
  assign w_total    = w_qCount + w_liveInflight + r_dropCnt;
  assign w_creditOk = (w_total < CW'(DEPTH));
  assign w_open     = r_active & w_creditOk & ~flush_i;

`ifdef FETCH_MISALIGN_CHK_EN
  // A misaligned PC waits until nothing is in flight so its error entry
  // lands in program order; it never reaches imem.
  assign w_misaligned = (pc_i[1:0] != 2'b00);
  assign pc_ready_o   = w_misaligned ? (w_open & (w_liveInflight == '0))
                                     : (w_open & imem_req_ready_i);
`else
  assign w_misaligned = 1'b0;
  assign pc_ready_o   = w_open & imem_req_ready_i;
`endif

  assign w_misFire        = pc_valid_i & pc_ready_o & w_misaligned;
  assign imem_req_valid_o = pc_valid_i & w_open & ~w_misaligned;
  assign imem_addr_o      = pc_i;
  assign w_reqFire        = imem_req_valid_o & imem_req_ready_i;

  // A response is kept only when no stale responses remain and a tag is
  // actually waiting; the second term swallows leftovers from before reset.
  assign imem_rsp_ready_o = r_active;
  assign w_rspFire        = imem_rsp_valid_i & imem_rsp_ready_o;
  assign w_rspKeep        = w_rspFire & ~flush_i & (r_dropCnt == '0)
                          & (w_liveInflight != '0);
  assign w_rspStale       = w_rspFire & ((r_dropCnt != '0) | (w_liveInflight != '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_active <= 1'b0;
    else         r_active <= 1'b1;
  end

  // On flush every live request becomes a drop, minus any response that is
  // being discarded in the flush cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dropCnt <= '0;
    end else if (flush_i) begin
      r_dropCnt <= r_dropCnt + w_liveInflight - CW'(w_rspStale);
    end else if (w_rspFire && (r_dropCnt != '0)) begin
      r_dropCnt <= r_dropCnt - CW'(1);
    end
  end

  // The tag FIFO occupancy is exactly the live in-flight count.
  fetch_fifo #(
    .T     (logic [31:0]),
    .DEPTH (DEPTH)
  ) u_tagFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_reqFire),
    .data_i  (pc_i),
    .pop_i   (w_rspKeep),
    .data_o  (w_tagPc),
    .count_o (w_liveInflight)
  );

  // Kept responses and misaligned markers are mutually exclusive: the
  // marker needs an empty tag FIFO, a kept response needs a non-empty one.
  assign w_qPush     = w_rspKeep | w_misFire;
  assign w_qPushData = w_misFire ? '{pc: pc_i, instr: NOP_INSTR, err: 1'b1}
                                 : '{pc: w_tagPc, instr: imem_instr_i, err: 1'b0};
  assign w_qPop      = w_idValid & id_ready_i;

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_qPush),
    .data_i  (w_qPushData),
    .pop_i   (w_qPop),
    .data_o  (w_head),
    .count_o (w_qCount)
  );

  // Head fields read as zero whenever the queue is empty.
  assign w_idValid   = (w_qCount != '0);
  assign id_valid_o  = w_idValid;
  assign id_pc_o     = w_idValid ? w_head.pc    : 32'h0;
  assign id_instr_o  = w_idValid ? w_head.instr : 32'h0;
  assign id_err_o    = w_idValid & w_head.err;
  assign occupancy_o = w_total;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus, a 1-cycle in-order
// imem model, and a scoreboard monitor that checks every IF/ID handshake.
module tb_fetch_unit;

  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          flush_i;
  logic          pc_valid_i;
  logic          pc_ready_o;
  logic [31:0]   pc_i;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i;
  logic [31:0]   imem_addr_o;
  logic          imem_rsp_valid_i;
  logic          imem_rsp_ready_o;
  logic [31:0]   imem_instr_i;
  logic          id_valid_o;
  logic          id_ready_i;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_instr_o;
  logic          id_err_o;
  logic [CW-1:0] occupancy_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] pending[$];
  bit          rspEnable;
  bit          sawAddr6;
  int          assertCount = 0;
  int          failCount = 0;

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .pc_valid_i       (pc_valid_i),
    .pc_ready_o       (pc_ready_o),
    .pc_i             (pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .imem_instr_i     (imem_instr_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o),
    .id_err_o         (id_err_o),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imemData(input logic [31:0] addr);
    return 32'hC0DE0000 | {16'h0000, addr[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: timed out waiting for DUT, expected completion", name);
  endtask

  task automatic applyStimulus(input logic pcValid, input logic [31:0] pc,
                               input logic idReady, input logic flush);
    pc_valid_i = pcValid;
    pc_i       = pc;
    id_ready_i = idReady;
    flush_i    = flush;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expPush(input logic [31:0] pc, input logic [31:0] instr, input logic err);
    exp_t e;
    e.pc = pc; e.instr = instr; e.err = err;
    expQ.push_back(e);
  endtask

  // Offer one PC until accepted; optionally record the entry it should yield.
  task automatic sendPc(input logic [31:0] pc, input bit keep,
                        input logic [31:0] expInstr, input logic expErr);
    bit fired = 0;
    pc_valid_i = 1'b1;
    pc_i       = pc;
    for (int c = 0; c < 20 && !fired; c++) begin
      @(negedge clk_i);
      if (pc_ready_o) begin
        fired = 1;
        if (keep) expPush(pc, expInstr, expErr);
      end
      cyc();
    end
    pc_valid_i = 1'b0;
    if (!fired) reportTimeout("send_pc");
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    for (int c = 0; c < maxCycles && expQ.size() != 0; c++) cyc();
    repeat (4) cyc();
    checkOutput(name, expQ.size(), 32'd0);
  endtask

  // imem model: requests seen at the falling edge are answered in order,
  // one per cycle, starting the next cycle, while rspEnable is set.
  initial begin
    imem_rsp_valid_i = 1'b0;
    imem_instr_i     = 32'h0;
    forever begin
      @(negedge clk_i);
      if (imem_req_valid_o && imem_req_ready_i) begin
        pending.push_back(imem_addr_o);
        if (imem_addr_o == 32'h6) sawAddr6 = 1;
      end
      @(posedge clk_i);
      #2;
      imem_rsp_valid_i = 1'b0;
      imem_instr_i     = 32'h0;
      if (rspEnable && pending.size() != 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_instr_i     = imemData(pending.pop_front());
      end
    end
  end

  // Scoreboard monitor: every IF/ID handshake must match the oldest
  // expected entry; a kept response must never find the tag FIFO empty.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (dut.w_rspKeep)
          checkOutput("tag_pop_nonempty", {31'b0, dut.w_liveInflight != 3'd0}, 32'd1);
        if (id_valid_o && id_ready_i) begin
          if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL id_unexpected: got pc 0x%08h instr 0x%08h, expected no output",
                     id_pc_o, id_instr_o);
          end else begin
            e = expQ.pop_front();
            checkOutput("id_pc", id_pc_o, e.pc);
            checkOutput("id_instr", id_instr_o, e.instr);
            checkOutput("id_err", {31'b0, id_err_o}, {31'b0, e.err});
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] instrs [5];
    int idx;
    int fires;

    rspEnable        = 1'b1;
    sawAddr6         = 1'b0;
    imem_req_ready_i = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);

    // Reset state
    #1 rst_ni = 1'b0;
    #2;
    checkOutput("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
    checkOutput("rst_id_pc", id_pc_o, 32'd0);
    checkOutput("rst_id_instr", id_instr_o, 32'd0);
    checkOutput("rst_id_err", {31'b0, id_err_o}, 32'd0);
    checkOutput("rst_occupancy", {29'b0, occupancy_o}, 32'd0);
    checkOutput("rst_rsp_ready", {31'b0, imem_rsp_ready_o}, 32'd0);
    checkOutput("rst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    pc_valid_i = 1'b0;
    cyc();
    @(negedge clk_i);
    checkOutput("rsp_ready_after_rst", {31'b0, imem_rsp_ready_o}, 32'd1);
    cyc();

    // 1. Streaming with a 1-cycle imem
    $display("[TB] streaming");
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk_i);
    checkOutput("t1_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    checkOutput("t1_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
    checkOutput("t1_req_addr", imem_addr_o, 32'h0);
    expPush(32'h0, 32'hC0DE0000, 1'b0);
    cyc();
    pc_i = 32'h4;
    @(negedge clk_i);
    checkOutput("t1_rsp_cycle_no_out", {31'b0, id_valid_o}, 32'd0);
    checkOutput("t1_pc_ready2", {31'b0, pc_ready_o}, 32'd1);
    expPush(32'h4, 32'hC0DE0004, 1'b0);
    cyc();
    pc_i = 32'h8;
    @(negedge clk_i);
    checkOutput("t1_first_valid", {31'b0, id_valid_o}, 32'd1);
    checkOutput("t1_first_pc", id_pc_o, 32'h0);
    expPush(32'h8, 32'hC0DE0008, 1'b0);
    cyc();
    pc_valid_i = 1'b0;
    waitDrain("t1_drain", 20);

    // 2. Backpressure fills exactly DEPTH credits
    $display("[TB] backpressure");
    pcs    = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    instrs = '{32'hC0DE0010, 32'hC0DE0014, 32'hC0DE0018, 32'hC0DE001C, 32'hC0DE0020};
    idx = 0;
    fires = 0;
    applyStimulus(1'b1, pcs[0], 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (pc_ready_o) begin
        fires++;
        if (idx < 4) begin
          expPush(pcs[idx], instrs[idx], 1'b0);
          idx++;
        end
      end
      cyc();
      pc_i = pcs[idx];
    end
    @(negedge clk_i);
    checkOutput("t2_fires", fires, 32'd4);
    checkOutput("t2_full_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    checkOutput("t2_full_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    checkOutput("t2_full_occupancy", {29'b0, occupancy_o}, 32'd4);
    checkOutput("t2_head_pc", id_pc_o, 32'h10);
    checkOutput("t2_head_instr", id_instr_o, 32'hC0DE0010);
    cyc();
    @(negedge clk_i);
    checkOutput("t2_head_stable", id_pc_o, 32'h10);
    cyc();
    id_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t2_no_comb_ready", {31'b0, pc_ready_o}, 32'd0);
    cyc();
    id_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t2_credit_freed", {31'b0, pc_ready_o}, 32'd1);
    checkOutput("t2_new_req_addr", imem_addr_o, 32'h20);
    checkOutput("t2_next_head", id_pc_o, 32'h14);
    if (pc_ready_o) expPush(32'h20, 32'hC0DE0020, 1'b0);
    cyc();
    pc_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t2_full_again", {31'b0, pc_ready_o}, 32'd0);
    cyc();
    id_ready_i = 1'b1;
    waitDrain("t2_drain", 30);

    // 3. Flush with three requests in flight
    $display("[TB] flush with 3 in flight");
    rspEnable = 1'b0;
    sendPc(32'h30, 1'b0, 32'h0, 1'b0);
    sendPc(32'h34, 1'b0, 32'h0, 1'b0);
    sendPc(32'h38, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk_i);
    checkOutput("t3_flush_blocks_ready", {31'b0, pc_ready_o}, 32'd0);
    checkOutput("t3_inflight_occ", {29'b0, occupancy_o}, 32'd3);
    cyc();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
    rspEnable = 1'b1;
    @(negedge clk_i);
    checkOutput("t3_valid_after_flush", {31'b0, id_valid_o}, 32'd0);
    checkOutput("t3_drop_occ", {29'b0, occupancy_o}, 32'd3);
    checkOutput("t3_new_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    if (pc_ready_o) expPush(32'h100, 32'hC0DE0100, 1'b0);
    cyc();
    pc_valid_i = 1'b0;
    waitDrain("t3_drain", 30);
    checkOutput("t3_occ_idle", {29'b0, occupancy_o}, 32'd0);

    // 4. Flush coincident with a response
    $display("[TB] flush coincident with response");
    rspEnable = 1'b0;
    sendPc(32'h50, 1'b0, 32'h0, 1'b0);
    sendPc(32'h54, 1'b0, 32'h0, 1'b0);
    rspEnable = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk_i);
    checkOutput("t4_occ_before", {29'b0, occupancy_o}, 32'd2);
    cyc();
    flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t4_drop_one", {29'b0, occupancy_o}, 32'd1);
    checkOutput("t4_no_valid", {31'b0, id_valid_o}, 32'd0);
    cyc();
    @(negedge clk_i);
    checkOutput("t4_drained", {29'b0, occupancy_o}, 32'd0);
    repeat (3) cyc();
    checkOutput("t4_nothing_out", expQ.size(), 32'd0);

    // 5. Asynchronous reset mid-stream
    $display("[TB] async reset mid-stream");
    id_ready_i = 1'b0;
    sendPc(32'h60, 1'b0, 32'h0, 1'b0);
    sendPc(32'h64, 1'b0, 32'h0, 1'b0);
    cyc();
    cyc();
    rspEnable = 1'b0;
    sendPc(32'h68, 1'b0, 32'h0, 1'b0);
    sendPc(32'h6C, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    checkOutput("t5_occ_before_rst", {29'b0, occupancy_o}, 32'd4);
    cyc();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("t5_rst_valid", {31'b0, id_valid_o}, 32'd0);
    checkOutput("t5_rst_pc", id_pc_o, 32'd0);
    checkOutput("t5_rst_occ", {29'b0, occupancy_o}, 32'd0);
    checkOutput("t5_rst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    checkOutput("t5_rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    pc_valid_i = 1'b0;
    rspEnable  = 1'b1;
    repeat (4) cyc();
    @(negedge clk_i);
    checkOutput("t5_stale_dropped_occ", {29'b0, occupancy_o}, 32'd0);
    checkOutput("t5_stale_no_valid", {31'b0, id_valid_o}, 32'd0);
    cyc();
    id_ready_i = 1'b1;
    sendPc(32'h40, 1'b1, 32'hC0DE0040, 1'b0);
    waitDrain("t5_drain", 20);

    // 6. Misaligned PC following an aligned one
    $display("[TB] misaligned pc");
    sawAddr6 = 1'b0;
    sendPc(32'h0, 1'b1, 32'hC0DE0000, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
    sendPc(32'h6, 1'b1, 32'h00000013, 1'b1);
    waitDrain("t6_drain", 20);
    checkOutput("t6_no_imem_req", {31'b0, sawAddr6}, 32'd0);
`else
    sendPc(32'h6, 1'b1, 32'hC0DE0006, 1'b0);
    waitDrain("t6_drain", 20);
    checkOutput("t6_imem_req", {31'b0, sawAddr6}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected $finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
